dds_sweep_core: RTL and testbench
=================================

Name: dds_sweep_core

Overview:
Parametrised successor to the single-tone DDS datapath in the DDS/AM-FM-PM block. It generates one signed waveform sample per clock from a phase accumulator. It adds a hardware linear frequency-sweep engine with single, loop and ping-pong modes, phase-sync reload, and a selectable waveform source (writable LUT RAM, saw, triangle, square). It sits between the dds register bank and the gain/offset/clamp modulation stage. FM and PM data come from the existing gain_offset_clamp outputs.

Parameters:
PHASE_WIDTH, 32, phase accumulator and step width
OUT_WIDTH, 8, signed output sample width
LUT_ADDR_WIDTH, 10, log2 of LUT RAM depth
MOD_WIDTH, 24, signed FM/PM input width (MOD_WIDTH <= PHASE_WIDTH)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wave_sel  in  2  waveform select: 0 LUT, 1 saw, 2 triangle, 3 square
step_start  in  PHASE_WIDTH  sweep start / idle tone step
step_stop  in  PHASE_WIDTH  sweep end step
step_delta  in  PHASE_WIDTH  unsigned step increment per dwell
dwell  in  32  cycles per sweep step (0 treated as 1)
sweep_mode  in  2  0 single, 1 loop, 2 ping-pong, 3 reserved (acts as single)
sweep_start  in  1  pulse: begin sweep
sweep_abort  in  1  pulse: return to IDLE
phase_sync  in  1  pulse: load accumulator with phase_offset
phase_offset  in  PHASE_WIDTH  accumulator load value
fm_data  in  MOD_WIDTH  signed step modulation
pm_data  in  MOD_WIDTH  signed phase modulation
lut_wr_en  in  1  LUT write strobe
lut_wr_addr  in  LUT_ADDR_WIDTH  LUT write address
lut_wr_data  in  OUT_WIDTH  LUT write data (signed)
out  out  OUT_WIDTH  signed sample
out_valid  out  1  sample valid
cur_step  out  PHASE_WIDTH  active step (before FM)
sweep_busy  out  1  FSM in RUN
sweep_done  out  1  one-cycle pulse at each sweep endpoint

Behaviour:
- Reset: acc=0, cur_step=step_start, FSM=IDLE, out=0, out_valid=0, sweep_busy=0, sweep_done=0. LUT contents are not reset.
- Accumulator runs every cycle: acc <= acc + cur_step + sext(fm_data), modulo 2^PHASE_WIDTH.
- phase_sync has priority over accumulation: acc <= phase_offset that cycle.
- Pipeline:
  - S1 register: ph = acc + (sext(pm_data) << (PHASE_WIDTH-MOD_WIDTH)), wraps.
  - S2 register: sample from ph.
  - out lags acc by 2 cycles. out_valid rises 2 cycles after reset release and stays 1.
- Waveforms, with t = top OUT_WIDTH bits of ph:
  - Saw: t with MSB inverted.
  - Square: ph MSB=0 gives +max (2^(OUT_WIDTH-1)-1); MSB=1 gives -max.
  - Triangle: fold of t, mapped so -max occurs at ph=0 and +max at ph=half period.
  - LUT: synchronous-read RAM addressed by the top LUT_ADDR_WIDTH bits of S1 ph.
  - All sources are aligned to the same 2-cycle latency.
- LUT write and read of the same address in the same cycle returns old data.
- Sweep direction: up if step_stop >= step_start (unsigned), else down. Inputs are sampled into shadow registers on sweep_start.
- FSM:
  - IDLE: cur_step=step_start (live). sweep_start: cur_step<=start, dwell_cnt<=max(dwell,1)-1, go to RUN.
  - RUN, sweep_busy=1: dwell_cnt decrements each cycle. At 0:
    - If next = cur_step ± delta would reach or pass stop (or overflow), cur_step<=stop, sweep_done pulses, go to END.
    - Otherwise cur_step<=next and dwell_cnt reloads.
  - END, taken the cycle after entry:
    - single: stay in HOLD at stop.
    - loop: cur_step<=start, go to RUN.
    - ping-pong: swap shadow start/stop, invert direction, go to RUN.
  - HOLD: cur_step=stop. sweep_start re-arms the sweep.
- step_delta=0 in RUN: cur_step never changes; sweep_done is never asserted.
- Priority: reset > sweep_abort > sweep_start. sweep_abort in any state goes to IDLE; acc is not touched. sweep_start in RUN restarts the sweep from start.
- Config inputs changed mid-sweep have no effect until the next sweep_start.

Test Plan:
- Defaults, step_start=0x01000000, wave_sel=1, fm=pm=0 -> saw sample ramps by 1 each cycle with a 256-cycle period; first sample after reset = -128 at cycle 2.
- wave_sel=3, same step -> 128 cycles of +127, then 128 cycles of -127. Then pulse phase_sync with offset 0x80000000 -> two cycles later out=-127.
- Sweep: start=0x100, stop=0x400, delta=0x100, dwell=4, single -> cur_step goes 0x100→0x200→0x300→0x400 at 4-cycle intervals; sweep_done pulses once; HOLD at 0x400.
- Ping-pong with the same values -> cur_step rises to 0x400, then falls to 0x100, then repeats; sweep_done pulses at each endpoint; sweep_busy stays 1.
- LUT: write addr k=k-128 for k=0..1023, wave_sel=0, step=0x00400000 -> out equals LUT[top 10 bits of phase] with 2-cycle latency. pm_data=0x400000 -> output advances by 256 addresses.
- sweep_abort during dwell with sweep_start in the same cycle -> FSM=IDLE, cur_step=step_start, no sweep_done. Reset asserted mid-RUN -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/dds_sweep_core.sv
// dds_sweep_core: phase-accumulator DDS with a linear step-sweep engine.
// Two-stage sample pipeline fed by LUT RAM, saw, triangle or square.
module dds_sweep_core #(
  parameter int PHASE_WIDTH    = 32,
  parameter int OUT_WIDTH      = 8,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int MOD_WIDTH      = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                wave_sel,
  input  logic [PHASE_WIDTH-1:0]    step_start,
  input  logic [PHASE_WIDTH-1:0]    step_stop,
  input  logic [PHASE_WIDTH-1:0]    step_delta,
  input  logic [31:0]               dwell,
  input  logic [1:0]                sweep_mode,
  input  logic                      sweep_start,
  input  logic                      sweep_abort,
  input  logic                      phase_sync,
  input  logic [PHASE_WIDTH-1:0]    phase_offset,
  input  logic [MOD_WIDTH-1:0]      fm_data,
  input  logic [MOD_WIDTH-1:0]      pm_data,
  input  logic                      lut_wr_en,
  input  logic [LUT_ADDR_WIDTH-1:0] lut_wr_addr,
  input  logic [OUT_WIDTH-1:0]      lut_wr_data,
  output logic [OUT_WIDTH-1:0]      out,
  output logic                      out_valid,
  output logic [PHASE_WIDTH-1:0]    cur_step,
  output logic                      sweep_busy,
  output logic                      sweep_done
);

  localparam int PW = PHASE_WIDTH;
  localparam int OW = OUT_WIDTH;
  localparam int LA = LUT_ADDR_WIDTH;
  localparam int MW = MOD_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_END,
    S_HOLD
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] cur_q, cur_n;
  logic [31:0]   cnt_q, cnt_n;
  logic [PW-1:0] sh_start, start_n;
  logic [PW-1:0] sh_stop, stop_n;
  logic [PW-1:0] sh_delta, delta_n;
  logic [31:0]   sh_dwell, dwell_n;
  logic [1:0]    sh_mode, mode_n;
  logic          sh_up, up_n;
  logic          done_q, done_n;

  logic [31:0]   dwell_m1;
  logic [PW:0]   sum_up;
  logic [PW:0]   diff_dn;
  logic          reach;
  logic [PW-1:0] nxt;
  logic          cont;

  logic [PW-1:0] fm_ext;
  logic [PW-1:0] pm_ext;
  logic [PW-1:0] acc;
  logic [PW-1:0] ph;
  logic          v1, v2;

  logic [OW-1:0] mem [2**LA];
  logic [OW-1:0] lut_q;
  logic [OW-1:0] wave_q;
  logic [OW-1:0] wave_d;
  logic [1:0]    sel_q;
  logic [OW-1:0] t;
  logic [OW-2:0] fold;
  logic          ph_unused;

  assign dwell_m1 = (dwell == 32'd0) ? 32'd0 : dwell - 32'd1;
  assign sum_up   = {1'b0, cur_q} + {1'b0, sh_delta};
  assign diff_dn  = {1'b0, cur_q} - {1'b0, sh_delta};
  assign nxt      = sh_up ? sum_up[PW-1:0] : diff_dn[PW-1:0];
  assign cont     = (sh_mode == 2'd1) || (sh_mode == 2'd2);

  // An overflow/borrow counts as passing the endpoint.
  assign reach = (sh_delta != '0) &&
                 (sh_up ? (sum_up[PW] || sum_up[PW-1:0] >= sh_stop)
                        : (diff_dn[PW] || diff_dn[PW-1:0] <= sh_stop));

  assign cur_step   = (state == S_IDLE) ? step_start : cur_q;
  assign sweep_busy = (state == S_RUN) || ((state == S_END) && cont);
  assign sweep_done = done_q;

  // Sweep FSM next state, next step and shadow updates.
  always_comb begin
    state_n = state;
    cur_n   = cur_q;
    cnt_n   = cnt_q;
    start_n = sh_start;
    stop_n  = sh_stop;
    delta_n = sh_delta;
    dwell_n = sh_dwell;
    mode_n  = sh_mode;
    up_n    = sh_up;
    done_n  = 1'b0;
    if (sweep_abort) begin
      state_n = S_IDLE;
    end else if (sweep_start) begin
      start_n = step_start;
      stop_n  = step_stop;
      delta_n = step_delta;
      dwell_n = dwell_m1;
      mode_n  = sweep_mode;
      up_n    = (step_stop >= step_start);
      cur_n   = step_start;
      cnt_n   = dwell_m1;
      state_n = S_RUN;
    end else begin
      unique case (state)
        S_RUN: begin
          if (cnt_q == 32'd0) begin
            if (reach) begin
              cur_n   = sh_stop;
              done_n  = 1'b1;
              state_n = S_END;
            end else begin
              cur_n = nxt;
              cnt_n = sh_dwell;
            end
          end else begin
            cnt_n = cnt_q - 32'd1;
          end
        end
        S_END: begin
          unique case (sh_mode)
            2'd1: begin
              cur_n   = sh_start;
              cnt_n   = sh_dwell;
              state_n = S_RUN;
            end
            2'd2: begin
              start_n = sh_stop;
              stop_n  = sh_start;
              up_n    = ~sh_up;
              cnt_n   = sh_dwell;
              state_n = S_RUN;
            end
            default: state_n = S_HOLD;
          endcase
        end
        default: state_n = state;
      endcase
    end
  end

  // Sweep FSM and shadow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cur_q    <= '0;
      cnt_q    <= '0;
      sh_start <= '0;
      sh_stop  <= '0;
      sh_delta <= '0;
      sh_dwell <= '0;
      sh_mode  <= '0;
      sh_up    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cur_q    <= cur_n;
      cnt_q    <= cnt_n;
      sh_start <= start_n;
      sh_stop  <= stop_n;
      sh_delta <= delta_n;
      sh_dwell <= dwell_n;
      sh_mode  <= mode_n;
      sh_up    <= up_n;
      done_q   <= done_n;
    end
  end

  assign fm_ext = PW'($signed(fm_data));
  assign pm_ext = PW'($signed(pm_data)) << (PW - MW);

  // Phase accumulator; phase_sync overrides the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (phase_sync) begin
      acc <= phase_offset;
    end else begin
      acc <= acc + cur_step + fm_ext;
    end
  end

  // S1: phase-modulated phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph <= '0;
      v1 <= 1'b0;
    end else begin
      ph <= acc + pm_ext;
      v1 <= 1'b1;
    end
  end

  assign t         = ph[PW-1 -: OW];
  assign fold      = t[OW-1] ? ~t[OW-2:0] : t[OW-2:0];
  assign ph_unused = ^ph;

  // Arithmetic waveform shapes derived from the S1 phase.
  always_comb begin
    wave_d = '0;
    unique case (wave_sel)
      2'd1: wave_d = {~t[OW-1], t[OW-2:0]};
      2'd2: wave_d = {~fold[OW-2], fold[OW-3:0], 1'b1};
      2'd3: wave_d = ph[PW-1] ? {1'b1, {(OW-2){1'b0}}, 1'b1}
                              : {1'b0, {(OW-1){1'b1}}};
      default: wave_d = '0;
    endcase
  end

  // LUT RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (lut_wr_en) begin
      mem[lut_wr_addr] <= lut_wr_data;
    end
  end

  // S2: LUT read and arithmetic sample registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      lut_q  <= '0;
      wave_q <= '0;
      sel_q  <= '0;
      v2     <= 1'b0;
    end else begin
      lut_q  <= mem[ph[PW-1 -: LA]];
      wave_q <= wave_d;
      sel_q  <= wave_sel;
      v2     <= v1;
    end
  end

  assign out       = (sel_q == 2'd0) ? lut_q : wave_q;
  assign out_valid = v2;

endmodule

// File: tb/tb_dds_sweep_core.sv
// tb_dds_sweep_core: vector table, reference model and sweep trajectories.
// Default parameters: 32-bit phase, 8-bit out, 1024-entry LUT, 24-bit mod.
module tb_dds_sweep_core;

  localparam longint MASK = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wave_sel;
  logic [31:0] step_start, step_stop, step_delta;
  logic [31:0] dwell;
  logic [1:0]  sweep_mode;
  logic        sweep_start, sweep_abort, phase_sync;
  logic [31:0] phase_offset;
  logic [23:0] fm_data, pm_data;
  logic        lut_wr_en;
  logic [9:0]  lut_wr_addr;
  logic [7:0]  lut_wr_data;
  logic [7:0]  out;
  logic        out_valid;
  logic [31:0] cur_step;
  logic        sweep_busy, sweep_done;

  always #5 clk = ~clk;

  dds_sweep_core dut (
    .clk(clk), .reset(reset), .wave_sel(wave_sel),
    .step_start(step_start), .step_stop(step_stop),
    .step_delta(step_delta), .dwell(dwell),
    .sweep_mode(sweep_mode), .sweep_start(sweep_start),
    .sweep_abort(sweep_abort), .phase_sync(phase_sync),
    .phase_offset(phase_offset), .fm_data(fm_data),
    .pm_data(pm_data), .lut_wr_en(lut_wr_en),
    .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
    .out(out), .out_valid(out_valid), .cur_step(cur_step),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done)
  );

  int checks = 0;
  int errors = 0;

  longint m_acc, m_ph;
  int     m_out, m_vcnt;
  int     lut_m [1024];
  bit     chk_out;

  longint ec[$];
  bit     ed[$], eb[$];

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] off;
    logic [23:0] pm;
    int          exp;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint sx(input logic [23:0] v);
    return longint'($signed(v));
  endfunction

  function automatic int wave_of(input longint p, input int sel);
    int tt;
    tt = int'(p >> 24);
    case (sel)
      0:       return lut_m[int'(p >> 22)];
      1:       return tt - 128;
      2:       return (tt < 128) ? 2 * tt - 127 : 383 - 2 * tt;
      default: return (p < 64'h8000_0000) ? 127 : -127;
    endcase
  endfunction

  task automatic tick();
    longint n_acc, n_ph;
    int n_out, n_v;
    if (reset) begin
      n_acc = 0; n_ph = 0; n_out = 0; n_v = 0;
    end else begin
      if (phase_sync) n_acc = longint'(phase_offset);
      else n_acc = (m_acc + longint'(step_start) + sx(fm_data)) & MASK;
      n_ph  = (m_acc + sx(pm_data) * 256) & MASK;
      n_out = wave_of(m_ph, int'(wave_sel));
      n_v   = (m_vcnt < 2) ? m_vcnt + 1 : 2;
    end
    if (lut_wr_en) lut_m[lut_wr_addr] = int'($signed(lut_wr_data));
    @(posedge clk);
    #1;
    m_acc = n_acc; m_ph = n_ph; m_out = n_out; m_vcnt = n_v;
    if (chk_out) begin
      chk("out", longint'($signed(out)), longint'(m_out));
      chk("out_valid", longint'(out_valid), longint'(m_vcnt == 2));
    end
  endtask

  task automatic push(input longint v, input bit d, input bit b);
    ec.push_back(v); ed.push_back(d); eb.push_back(b);
  endtask

  // Expected trajectory: each point held for the dwell, endpoint
  // flagged with done, legs repeated according to the mode.
  task automatic build(input int mode, input longint a0,
                       input longint b0, input longint d,
                       input int dw, input int n);
    longint a, b, v, nx, tmp;
    int de;
    bit cont, up, fin;
    a = a0; b = b0;
    de = (dw == 0) ? 1 : dw;
    cont = (mode == 1) || (mode == 2);
    ec.delete(); ed.delete(); eb.delete();
    while (ec.size() < n) begin
      if (d == 0) begin
        while (ec.size() < n) push(a, 0, 1);
        break;
      end
      v = a; up = (b >= a); fin = 0;
      while (!fin) begin
        repeat (de) push(v, 0, 1);
        nx = up ? v + d : v - d;
        if (up ? (nx >= b) : (nx <= b)) fin = 1;
        else v = nx;
      end
      push(b, 1, cont);
      if (!cont) begin
        while (ec.size() < n) push(b, 0, 0);
      end else if (mode == 2) begin
        tmp = a; a = b; b = tmp;
      end
    end
  endtask

  task automatic cmp_sweep(input string nm, input int i);
    chk({nm, "_cur"}, longint'(cur_step), ec[i]);
    chk({nm, "_done"}, longint'(sweep_done), longint'(ed[i]));
    chk({nm, "_busy"}, longint'(sweep_busy), longint'(eb[i]));
  endtask

  task automatic run_sweep(input string nm, input int mode,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] d, input int dw,
                           input int n);
    build(mode, longint'(a), longint'(b), longint'(d), dw, n);
    step_start = a; step_stop = b; step_delta = d;
    dwell = dw; sweep_mode = 2'(mode);
    sweep_start = 1; tick(); sweep_start = 0;
    step_start = $urandom; step_stop = $urandom;
    step_delta = $urandom; dwell = $urandom_range(0, 9);
    sweep_mode = 2'($urandom);
    cmp_sweep(nm, 0);
    for (int i = 1; i < n; i++) begin
      tick();
      cmp_sweep(nm, i);
    end
  endtask

  initial begin
    vt[0]  = '{2'd1, 32'h0000_0000, 24'h0,       -128};
    vt[1]  = '{2'd1, 32'h8000_0000, 24'h0,       0};
    vt[2]  = '{2'd1, 32'hFF00_0000, 24'h0,       127};
    vt[3]  = '{2'd3, 32'h7FFF_FFFF, 24'h0,       127};
    vt[4]  = '{2'd3, 32'h8000_0000, 24'h0,       -127};
    vt[5]  = '{2'd2, 32'h0000_0000, 24'h0,       -127};
    vt[6]  = '{2'd2, 32'h8000_0000, 24'h0,       127};
    vt[7]  = '{2'd2, 32'h4000_0000, 24'h0,       1};
    vt[8]  = '{2'd2, 32'hC000_0000, 24'h0,       -1};
    vt[9]  = '{2'd1, 32'h0000_0000, 24'h40_0000, -64};
    vt[10] = '{2'd3, 32'h1000_0000, 24'h80_0000, -127};
    vt[11] = '{2'd2, 32'h0000_0000, 24'hFF_FFFF, -127};

    reset = 1; wave_sel = 1; step_start = 32'h0100_0000;
    step_stop = 0; step_delta = 0; dwell = 0; sweep_mode = 0;
    sweep_start = 0; sweep_abort = 0; phase_sync = 0;
    phase_offset = 0; fm_data = 0; pm_data = 0;
    lut_wr_en = 0; lut_wr_addr = 0; lut_wr_data = 0;
    chk_out = 0;
    m_acc = 0; m_ph = 0; m_out = 0; m_vcnt = 0;
    repeat (3) tick();
    chk("rst_out", longint'(out), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(sweep_busy), 0);
    chk("rst_done", longint'(sweep_done), 0);
    chk("rst_cur", longint'(cur_step), 64'h0100_0000);

    reset = 0; chk_out = 1;
    tick(); tick();
    chk("first_saw", longint'($signed(out)), -128);
    chk("first_valid", longint'(out_valid), 1);
    repeat (300) tick();
    wave_sel = 3;
    repeat (300) tick();
    phase_sync = 1; phase_offset = 32'h8000_0000;
    tick(); phase_sync = 0;
    tick(); tick();
    chk("psync_sq", longint'($signed(out)), -127);

    foreach (vt[i]) begin
      wave_sel = vt[i].sel; phase_offset = vt[i].off;
      pm_data = vt[i].pm; phase_sync = 1;
      repeat (3) tick();
      chk($sformatf("vec%0d", i), longint'($signed(out)),
          longint'(vt[i].exp));
    end
    phase_sync = 0; pm_data = 0; wave_sel = 1;

    for (int k = 0; k < 1024; k++) begin
      lut_wr_en = 1; lut_wr_addr = 10'(k); lut_wr_data = 8'(k - 128);
      tick();
    end
    lut_wr_en = 0;
    wave_sel = 0; step_start = 32'h0040_0000;
    repeat (600) tick();
    pm_data = 24'h40_0000;
    repeat (100) tick();

    step_start = 0; pm_data = 0;
    phase_sync = 1; phase_offset = 32'(5) << 22;
    repeat (3) tick();
    chk("lut5", longint'($signed(out)), -123);
    lut_wr_en = 1; lut_wr_addr = 5; lut_wr_data = 8'd77;
    tick(); lut_wr_en = 0;
    chk("rw_old", longint'($signed(out)), -123);
    tick();
    chk("rw_new", longint'($signed(out)), 77);
    phase_sync = 0;

    for (int i = 0; i < 1500; i++) begin
      step_start = $urandom; wave_sel = 2'($urandom);
      fm_data = 24'($urandom); pm_data = 24'($urandom);
      phase_sync = ($urandom_range(0, 15) == 0);
      phase_offset = $urandom;
      lut_wr_en = 1'($urandom); lut_wr_addr = 10'($urandom);
      lut_wr_data = 8'($urandom);
      tick();
    end
    phase_sync = 0; lut_wr_en = 0; fm_data = 0; pm_data = 0;

    chk_out = 0;
    run_sweep("single", 0, 32'h100, 32'h400, 32'h100, 4, 30);
    run_sweep("pingpong", 2, 32'h100, 32'h400, 32'h100, 4, 70);
    run_sweep("loop", 1, 32'h100, 32'h400, 32'h100, 4, 20);
    run_sweep("restart", 1, 32'h100, 32'h400, 32'h100, 4, 40);
    run_sweep("ovf", 0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 0, 8);
    run_sweep("down", 0, 32'h1000, 32'h10, 32'h300, 2, 20);
    run_sweep("rsvd", 3, 32'h10, 32'h30, 32'h10, 1, 8);
    run_sweep("zdelta", 2, 32'h100, 32'h400, 32'h0, 3, 30);

    step_start = 32'h100; step_stop = 32'h400;
    step_delta = 32'h100; dwell = 4; sweep_mode = 0;
    sweep_start = 1; tick(); sweep_start = 0;
    tick();
    step_start = 32'h1234;
    sweep_abort = 1; sweep_start = 1; tick();
    sweep_abort = 0; sweep_start = 0;
    chk("abort_busy", longint'(sweep_busy), 0);
    chk("abort_cur", longint'(cur_step), 64'h1234);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort_done", longint'(sweep_done), 0);
    end
    step_start = 32'h777; #1;
    chk("idle_live", longint'(cur_step), 64'h777);

    step_start = 32'h100; sweep_start = 1; tick(); sweep_start = 0;
    repeat (5) tick();
    chk("mid_busy", longint'(sweep_busy), 1);
    reset = 1; tick(); reset = 0;
    chk("mrst_out", longint'(out), 0);
    chk("mrst_valid", longint'(out_valid), 0);
    chk("mrst_busy", longint'(sweep_busy), 0);
    chk("mrst_done", longint'(sweep_done), 0);
    chk("mrst_cur", longint'(cur_step), 64'h100);
    tick();
    chk("mrst_v1", longint'(out_valid), 0);
    tick();
    chk("mrst_v2", longint'(out_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
